// File: rtl/rc_scan_scheduler_pkg.sv
// Shared RC-input constants, scheduler state and result encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rc_pkg;

    // Scheduler FSM states
    localparam logic [1:0] ST_ARM   = 2'd0;
    localparam logic [1:0] ST_RISE  = 2'd1;
    localparam logic [1:0] ST_MEAS  = 2'd2;
    localparam logic [1:0] ST_STORE = 2'd3;

    // Outcome of one channel visit, consumed in ST_STORE
    localparam logic [1:0] RES_OK      = 2'd0;
    localparam logic [1:0] RES_LOST    = 2'd1;
    localparam logic [1:0] RES_DISCARD = 2'd2;

    // Standard RC servo pulse limits, shared with the command-mapping logic
    localparam int RC_MIN_US    = 800;
    localparam int RC_MAX_US    = 2200;
    localparam int RC_CENTER_US = 1500;

    // Round-robin successor of v in 0..n-1
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rc_scan_scheduler_if.sv
// Bundle of RC scan scheduler pins: raw inputs, readback port, flags, update strobe.
// Latency: n/a (wires only).
// Backpressure: none; all signals are free-running.
// Ports: pulse_in (raw RC pins), rd_addr/rd_data/rd_valid (readback),
//        lost (per-channel flags), upd_stb/upd_ch (result-written strobe).
interface rc_scan_scheduler_if #(
    parameter int NCH   = 4,
    parameter int LEN_W = 12
);
    localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   pulse_in;
    logic [AW-1:0]    rd_addr;
    logic [LEN_W-1:0] rd_data;
    logic             rd_valid;
    logic [NCH-1:0]   lost;
    logic             upd_stb;
    logic [AW-1:0]    upd_ch;

    // Host side: drives the pins and read address, observes results
    modport master (
        output pulse_in, rd_addr,
        input  rd_data, rd_valid, lost, upd_stb, upd_ch
    );

    // Scheduler side
    modport slave (
        input  pulse_in, rd_addr,
        output rd_data, rd_valid, lost, upd_stb, upd_ch
    );
endinterface

// File: rtl/rc_scan_scheduler_us_tick.sv
// Microsecond prescaler: one-cycle tick every PREDIV clk cycles.
// Latency: first tick PREDIV cycles after restart is released.
// Backpressure: none; restart synchronously zeroes the phase and suppresses the tick.
// Ports: clk, reset (async high), restart (sync phase reset), tick (1-cycle pulse).
module rc_us_tick #(
    parameter int PREDIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CW = (PREDIV > 1) ? $clog2(PREDIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_end;

    always_comb begin
        at_end = (cnt_q == CW'(PREDIV - 1));
        tick   = at_end && !restart;
        if (restart || at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rc_scan_scheduler.sv
// Round-robin pulse-width measurement of NCH RC inputs with one shared us counter.
// Latency: readback 1 cycle from rd_addr; upd_stb 1 cycle after the store state.
// Backpressure: none; results overwrite the bank, lost/invalid flagged per channel.
// Ports: clk, reset (async high), bus (slave modport of rc_scan_scheduler_if).
module rc_scan_scheduler
    import rc_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int PREDIV     = 50,
    parameter int LEN_W      = 12,
    parameter int MIN_US     = RC_MIN_US,
    parameter int MAX_US     = RC_MAX_US,
    parameter int TIMEOUT_US = 25000
) (
    input  logic                clk,
    input  logic                reset,
    rc_scan_scheduler_if.slave  bus
);
    localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TIMEOUT_US + 1);

    logic [NCH-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       state_q, state_d;
    logic [1:0]       res_q, res_d;
    logic [AW-1:0]    ch_q, ch_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic [LEN_W-1:0] bank_q [NCH];
    logic [LEN_W-1:0] bank_d [NCH];
    logic [NCH-1:0]   valid_q, valid_d, lost_q, lost_d;
    logic             upd_stb_q, upd_stb_d;
    logic [AW-1:0]    upd_ch_q, upd_ch_d;
    logic [LEN_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic             sel_lvl;
    logic             tick;
    logic             restart;
    logic             to_hit;
    logic             addr_ok;
    logic [TW-1:0]    to_inc;
    logic [LEN_W-1:0] len_fin;

    rc_us_tick #(.PREDIV(PREDIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Out-of-range read addresses only exist when NCH is not a power of two
    generate
        if ((1 << AW) == NCH) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = (bus.rd_addr < AW'(NCH));
        end
    endgenerate

    // Only the selected channel's synchronised level matters; since ARM
    // guarantees a low level before RISE, a high level in RISE is a rising
    // edge and a low level in MEAS is a falling edge.
    assign sel_lvl = sync2_q[ch_q];

    always_comb begin
        sync1_d    = bus.pulse_in;
        sync2_d    = sync1_q;
        state_d    = state_q;
        res_d      = res_q;
        ch_d       = ch_q;
        to_cnt_d   = to_cnt_q;
        len_cnt_d  = len_cnt_q;
        bank_d     = bank_q;
        valid_d    = valid_q;
        lost_d     = lost_q;
        upd_stb_d  = 1'b0;
        upd_ch_d   = upd_ch_q;
        restart    = 1'b0;

        to_inc  = (tick && (to_cnt_q != '1)) ? to_cnt_q + TW'(1) : to_cnt_q;
        // >= so a timeout coinciding with the ARM->RISE step still fires in RISE
        to_hit  = tick && (to_cnt_q >= TW'(TIMEOUT_US - 1));
        // The tick landing on the falling-edge cycle still belongs to the pulse
        len_fin = (tick && (len_cnt_q != '1)) ? len_cnt_q + LEN_W'(1) : len_cnt_q;

        case (state_q)
            ST_ARM: begin
                to_cnt_d = to_inc;
                if (!sel_lvl) begin
                    state_d = ST_RISE;
                end else if (to_hit) begin
                    res_d   = RES_LOST;
                    state_d = ST_STORE;
                end
            end
            ST_RISE: begin
                if (sel_lvl) begin
                    restart   = 1'b1;
                    len_cnt_d = '0;
                    state_d   = ST_MEAS;
                end else if (to_hit) begin
                    res_d   = RES_LOST;
                    state_d = ST_STORE;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            ST_MEAS: begin
                if (!sel_lvl) begin
                    len_cnt_d = len_fin;
                    res_d     = ((len_fin >= LEN_W'(MIN_US)) && (len_fin <= LEN_W'(MAX_US)))
                              ? RES_OK : RES_DISCARD;
                    state_d   = ST_STORE;
                end else if (tick) begin
                    // Reaching MAX_US+1 ends the visit, so the count never wraps
                    if (len_cnt_q == LEN_W'(MAX_US)) begin
                        res_d   = RES_LOST;
                        state_d = ST_STORE;
                    end else begin
                        len_cnt_d = len_cnt_q + LEN_W'(1);
                    end
                end
            end
            ST_STORE: begin
                case (res_q)
                    RES_OK: begin
                        bank_d[ch_q]  = len_cnt_q;
                        valid_d[ch_q] = 1'b1;
                        lost_d[ch_q]  = 1'b0;
                        upd_stb_d     = 1'b1;
                        upd_ch_d      = ch_q;
                    end
                    RES_LOST: begin
                        valid_d[ch_q] = 1'b0;
                        lost_d[ch_q]  = 1'b1;
                    end
                    default: ;
                endcase
                ch_d     = AW'(wrap_inc(32'(ch_q), NCH));
                to_cnt_d = '0;
                restart  = 1'b1;
                state_d  = ST_ARM;
            end
            default: state_d = ST_ARM;
        endcase

        // Reads the pre-write bank, so a same-cycle write shows up one cycle later
        rd_data_d  = addr_ok ? bank_q[bus.rd_addr]  : '0;
        rd_valid_d = addr_ok ? valid_q[bus.rd_addr] : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q    <= ST_ARM;
            res_q      <= RES_DISCARD;
            ch_q       <= '0;
            to_cnt_q   <= '0;
            len_cnt_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                bank_q[i] <= '0;
            end
            valid_q    <= '0;
            lost_q     <= '0;
            upd_stb_q  <= 1'b0;
            upd_ch_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            res_q      <= res_d;
            ch_q       <= ch_d;
            to_cnt_q   <= to_cnt_d;
            len_cnt_q  <= len_cnt_d;
            bank_q     <= bank_d;
            valid_q    <= valid_d;
            lost_q     <= lost_d;
            upd_stb_q  <= upd_stb_d;
            upd_ch_q   <= upd_ch_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.lost     = lost_q;
    assign bus.upd_stb  = upd_stb_q;
    assign bus.upd_ch   = upd_ch_q;
endmodule

// File: tb/tb_rc_scan_scheduler.sv
// Self-checking bench for rc_scan_scheduler with scaled-down timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_rc_scan_scheduler;
    localparam int NCH        = 4;
    localparam int PREDIV     = 4;
    localparam int LEN_W      = 12;
    localparam int MIN_US     = 8;
    localparam int MAX_US     = 22;
    localparam int TIMEOUT_US = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rc_scan_scheduler_if #(.NCH(NCH), .LEN_W(LEN_W)) bus_if ();

    rc_scan_scheduler #(
        .NCH(NCH), .PREDIV(PREDIV), .LEN_W(LEN_W),
        .MIN_US(MIN_US), .MAX_US(MAX_US), .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    typedef struct { int ch; int lo; int hi; } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_checks     = 0;
    int   n_fail       = 0;
    int   upd_count    = 0;
    int   cyc          = 0;
    int   last_upd_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every strobe must match the oldest expected update
    always @(negedge clk) begin
        if (!rst && bus_if.upd_stb) begin
            upd_count    = upd_count + 1;
            last_upd_cyc = cyc;
            n_checks     = n_checks + 1;
            if (sb_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL upd_unexpected: upd_stb with upd_ch=%0d, required no strobe", bus_if.upd_ch);
            end else begin
                last_exp = sb_q.pop_front();
                if (int'(bus_if.upd_ch) !== last_exp.ch) begin
                    n_fail = n_fail + 1;
                    $display("FAIL upd_ch: got %0d, required %0d", bus_if.upd_ch, last_exp.ch);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_upd(input int start, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (upd_count > start) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.pulse_in = '0;
        bus_if.rd_addr  = '0;
        step(3);
        n_checks++; if (bus_if.lost !== 4'b0) begin n_fail++; $display("FAIL reset_lost: got %b, required 0000", bus_if.lost); end
        n_checks++; if (bus_if.upd_stb !== 1'b0) begin n_fail++; $display("FAIL reset_upd_stb: got %b, required 0", bus_if.upd_stb); end
        n_checks++; if (bus_if.rd_data !== 12'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0d, required 0", bus_if.rd_data); end
        n_checks++; if (bus_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b, required 0", bus_if.rd_valid); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_basic();
        int start;
        bit ok;
        bus_if.rd_addr = 2'd1;
        sb_q.push_back('{0, 14, 15});
        start = upd_count;
        bus_if.pulse_in[0] = 1'b1; step(60); bus_if.pulse_in[0] = 1'b0;
        wait_upd(start, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_ch0_timeout: got no strobe, required strobe within 20 cycles"); end

        sb_q.push_back('{1, 9, 10});
        start = upd_count;
        bus_if.pulse_in[1] = 1'b1; step(40); bus_if.pulse_in[1] = 1'b0;
        wait_upd(start, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_ch1_timeout: got no strobe, required strobe within 20 cycles"); end
        // Same-cycle write/read of ch1 returns the old value
        n_checks++; if (bus_if.rd_data !== 12'd0 || bus_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_old_value: got %0d/%b, required 0/0", bus_if.rd_data, bus_if.rd_valid); end
        step(1);
        n_checks++; if (bus_if.rd_data < 9 || bus_if.rd_data > 10 || bus_if.rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ch1_read: got %0d/%b, required 9..10/1", bus_if.rd_data, bus_if.rd_valid); end
        bus_if.rd_addr = 2'd0;
        step(1);
        n_checks++; if (bus_if.rd_data < 14 || bus_if.rd_data > 15 || bus_if.rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ch0_read: got %0d/%b, required 14..15/1", bus_if.rd_data, bus_if.rd_valid); end
    endtask

    task automatic test_timeout();
        int start;
        int elapsed;
        bit found;
        start = upd_count;
        bus_if.pulse_in[3] = 1'b1;   // ch3 already high when its turn comes
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus_if.lost[2]) begin found = 1'b1; break; end
            step(1);
        end
        elapsed = cyc - last_upd_cyc;
        n_checks++; if (!found) begin n_fail++; $display("FAIL timeout_lost2: got lost=%b, required lost[2]=1", bus_if.lost); end
        n_checks++; if (elapsed < 239 || elapsed > 243) begin n_fail++; $display("FAIL timeout_time: got %0d cycles, required 239..243", elapsed); end
        bus_if.rd_addr = 2'd2;
        step(1);
        n_checks++; if (bus_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_valid2: got %b, required 0", bus_if.rd_valid); end
        n_checks++; if (upd_count !== start) begin n_fail++; $display("FAIL timeout_no_upd: got %0d strobes, required 0", upd_count - start); end
    endtask

    task automatic test_stuck_high();
        int start;
        start = upd_count;
        step(80);
        n_checks++; if (bus_if.lost[3] !== 1'b0) begin n_fail++; $display("FAIL stuck_arm_block: got lost[3]=%b, required 0", bus_if.lost[3]); end
        bus_if.pulse_in[3] = 1'b0; step(8);
        bus_if.pulse_in[3] = 1'b1; step(80);
        n_checks++; if (bus_if.lost[3] !== 1'b0) begin n_fail++; $display("FAIL stuck_early: got lost[3]=%b at 20 ticks, required 0", bus_if.lost[3]); end
        step(30);
        n_checks++; if (bus_if.lost[3] !== 1'b1) begin n_fail++; $display("FAIL stuck_lost3: got %b, required 1", bus_if.lost[3]); end
        bus_if.rd_addr = 2'd3;
        step(1);
        n_checks++; if (bus_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL stuck_valid3: got %b, required 0", bus_if.rd_valid); end
        n_checks++; if (upd_count !== start) begin n_fail++; $display("FAIL stuck_no_upd: got %0d strobes, required 0", upd_count - start); end
        bus_if.pulse_in[3] = 1'b0;
        step(2);
    endtask

    task automatic test_ignore_others();
        int start;
        bit ok;
        exp_t e;
        e = '{0, 11, 12};
        sb_q.push_back(e);
        start = upd_count;
        for (int i = 0; i < 120; i++) begin
            bus_if.pulse_in[0] = (i < 48);
            bus_if.pulse_in[1] = (i >= 10);            // still high when ch1's turn starts
            bus_if.pulse_in[2] = (i >= 5 && i < 26);
            bus_if.pulse_in[3] = (i >= 20 && i < 41);
            step(1);
        end
        bus_if.pulse_in = '0;
        n_checks++; if (upd_count !== start + 1) begin n_fail++; $display("FAIL ignore_upd_count: got %0d strobes, required 1", upd_count - start); end
        bus_if.rd_addr = 2'd0;
        step(1);
        n_checks++; if (bus_if.rd_data < e.lo || bus_if.rd_data > e.hi) begin n_fail++; $display("FAIL ignore_ch0_len: got %0d, required %0d..%0d", bus_if.rd_data, e.lo, e.hi); end

        e = '{1, 12, 13};
        sb_q.push_back(e);
        start = upd_count;
        step(8);
        bus_if.pulse_in[1] = 1'b1; step(52); bus_if.pulse_in[1] = 1'b0;
        wait_upd(start, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ignore_ch1_timeout: got no strobe, required strobe within 20 cycles"); end
        bus_if.rd_addr = 2'd1;
        step(2);
        n_checks++; if (bus_if.rd_data < e.lo || bus_if.rd_data > e.hi) begin n_fail++; $display("FAIL ignore_ch1_len: got %0d, required %0d..%0d", bus_if.rd_data, e.lo, e.hi); end
    endtask

    task automatic test_short_pulse();
        int start;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (bus_if.lost[0]) begin found = 1'b1; break; end
            step(1);
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL short_wait_lost0: got lost=%b, required lost[0]=1", bus_if.lost); end
        start = upd_count;
        step(4);
        bus_if.pulse_in[1] = 1'b1; step(20); bus_if.pulse_in[1] = 1'b0;
        step(30);
        n_checks++; if (upd_count !== start) begin n_fail++; $display("FAIL short_no_upd: got %0d strobes, required 0", upd_count - start); end
        bus_if.rd_addr = 2'd1;
        step(1);
        n_checks++; if (bus_if.rd_data < 12 || bus_if.rd_data > 13 || bus_if.rd_valid !== 1'b1) begin n_fail++; $display("FAIL short_retained: got %0d/%b, required 12..13/1", bus_if.rd_data, bus_if.rd_valid); end
        n_checks++; if (bus_if.lost[1] !== 1'b0) begin n_fail++; $display("FAIL short_lost1: got %b, required 0", bus_if.lost[1]); end
    endtask

    task automatic test_reset_mid();
        int start;
        bit ok;
        step(4);
        bus_if.pulse_in[2] = 1'b1;
        step(20);
        rst = 1'b1;
        #1;
        n_checks++; if (bus_if.lost !== 4'b0) begin n_fail++; $display("FAIL rstmid_lost: got %b, required 0000", bus_if.lost); end
        n_checks++; if (bus_if.rd_data !== 12'd0 || bus_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_read: got %0d/%b, required 0/0", bus_if.rd_data, bus_if.rd_valid); end
        n_checks++; if (bus_if.upd_stb !== 1'b0 || bus_if.upd_ch !== 2'd0) begin n_fail++; $display("FAIL rstmid_upd: got %b/%0d, required 0/0", bus_if.upd_stb, bus_if.upd_ch); end
        step(3);
        rst = 1'b0;
        step(1);
        n_checks++; if (bus_if.rd_data !== 12'd0 || bus_if.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_bank1: got %0d/%b, required 0/0", bus_if.rd_data, bus_if.rd_valid); end
        sb_q.push_back('{0, 9, 10});
        start = upd_count;
        step(2);
        bus_if.pulse_in[0] = 1'b1; step(40); bus_if.pulse_in[0] = 1'b0;
        wait_upd(start, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_ch0_first: got no strobe, required strobe for ch0 within 20 cycles"); end
        bus_if.pulse_in[2] = 1'b0;
        bus_if.rd_addr = 2'd0;
        step(2);
        n_checks++; if (bus_if.rd_data < 9 || bus_if.rd_data > 10 || bus_if.rd_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_ch0_len: got %0d/%b, required 9..10/1", bus_if.rd_data, bus_if.rd_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_stuck_high();
        test_ignore_others();
        test_short_pulse();
        test_reset_mid();
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending updates, required 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
